// File: rtl/beat_gen.sv
// beat_gen: machine-cycle beat sequencer.
// Emits the W1/W2/W3 beats of each machine cycle, one beat per rising t3
// edge, under control of start, single-step, short, long and stop requests.
//
// Ports:
//   t3       in   beat clock, state advances on the rising edge
//   clr      in   asynchronous active-low reset
//   qd       in   start request level; a start is a 0->1 edge sampled on t3
//   step     in   1 = halt after every completed machine cycle
//   short    in   current cycle ends after W1
//   long     in   current cycle extends to W3
//   stop     in   halt at the end of the current beat
//   w1/w2/w3 out  beat strobes, at most one high
//   running  out  high while any beat is active
//   cyc_cnt  out  completed machine cycle count, wraps
//
// state  | meaning
// IDLE   | halted, waiting for a qd 0->1 edge
// W1     | first beat of a machine cycle
// W2     | second beat
// W3     | third beat, only when long was seen in W2
module beat_gen #(
  parameter int CNT_W = 16
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             qd,
  input  logic             step,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             running,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_W1   = 2'd1,
    S_W2   = 2'd2,
    S_W3   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             qd_q, qd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start;
  logic             cycle_done;
  state_t           end_state;

  // qd_q resets high so a switch held on through reset cannot start us.
  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      qd_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      qd_q    <= qd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    qd_d       = qd;
    start      = qd & ~qd_q;
    state_d    = state_q;
    end_state  = step ? S_IDLE : S_W1;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_W1;
      end
      S_W1: begin
        if (stop)       state_d = S_IDLE;
        else if (short) state_d = end_state;
        else            state_d = S_W2;
      end
      S_W2: begin
        if (stop)      state_d = S_IDLE;
        else if (long) state_d = S_W3;
        else           state_d = end_state;
      end
      S_W3: begin
        if (stop) state_d = S_IDLE;
        else      state_d = end_state;
      end
      default: state_d = S_IDLE;
    endcase

    // Any exit from an active beat back to W1 or IDLE closes a cycle,
    // including stop-terminated ones.
    cycle_done = (state_q != S_IDLE) &&
                 ((state_d == S_IDLE) || (state_d == S_W1));
    cnt_d      = cycle_done ? cnt_q + 1'b1 : cnt_q;
  end

  always_comb begin
    w1      = (state_q == S_W1);
    w2      = (state_q == S_W2);
    w3      = (state_q == S_W3);
    running = (state_q != S_IDLE);
    cyc_cnt = cnt_q;
  end

endmodule

// File: tb/tb_beat_gen.sv
// tb_beat_gen: directed scenarios for beat_gen (CNT_W=4 so wrap is reachable).
// Each scenario builds a stimulus table; the expected beat/count for every
// row is pushed to a scoreboard queue as the row is driven and popped and
// compared once the t3 edge has been taken.
module tb_beat_gen;

  localparam int CW = 4;
  // {running, w3, w2, w1}
  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_W1   = 4'b1001;
  localparam logic [3:0] O_W2   = 4'b1010;
  localparam logic [3:0] O_W3   = 4'b1100;

  typedef struct packed {
    logic          qd, step, sh, lg, sp;
    logic [3:0]    o;
    logic [CW-1:0] c;
  } vec_t;

  typedef struct packed {
    logic [3:0]    o;
    logic [CW-1:0] c;
  } exp_t;

  logic t3 = 1'b0;
  logic clr, qd, step, short, long, stop;
  logic w1, w2, w3, running;
  logic [CW-1:0] cyc_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t exp_q[$];

  beat_gen #(.CNT_W(CW)) dut (
    .t3(t3), .clr(clr), .qd(qd), .step(step), .short(short), .long(long),
    .stop(stop), .w1(w1), .w2(w2), .w3(w3), .running(running),
    .cyc_cnt(cyc_cnt)
  );

  always #5 t3 = ~t3;

  function automatic vec_t v(logic q, logic st, logic sh, logic lg, logic sp,
                             logic [3:0] o, int c);
    vec_t r;
    r.qd = q; r.step = st; r.sh = sh; r.lg = lg; r.sp = sp;
    r.o = o; r.c = CW'(c);
    return r;
  endfunction

  task automatic tick();
    @(posedge t3);
    #1;
  endtask

  task automatic drive(vec_t r);
    qd = r.qd; step = r.step; short = r.sh; long = r.lg; stop = r.sp;
    exp_q.push_back('{o: r.o, c: r.c});
  endtask

  task automatic do_reset();
    step = 0; short = 0; long = 0; stop = 0;
    clr = 1'b0;
    #2;
    clr = 1'b1;
  endtask

  task automatic test_reset();
    vec_t t[$];
    exp_t e;
    qd = 1'b1;
    do_reset();
    clr = 1'b0;
    #1;
    tests_run++;
    if ({running, w3, w2, w1} !== O_IDLE || cyc_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold: outs=%b cnt=%0d, want outs=%b cnt=0",
               {running, w3, w2, w1}, cyc_cnt, O_IDLE);
    end
    clr = 1'b1;
    for (int i = 0; i < 5; i++) t.push_back(v(1, 0, 0, 0, 0, O_IDLE, 0));
    t.push_back(v(0, 0, 0, 0, 0, O_IDLE, 0));
    t.push_back(v(1, 0, 0, 0, 0, O_W1, 0));
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({running, w3, w2, w1} !== e.o || cyc_cnt !== e.c) begin
        tests_failed++;
        $display("FAIL reset[%0d]: outs=%b cnt=%0d, want outs=%b cnt=%0d",
                 i, {running, w3, w2, w1}, cyc_cnt, e.o, e.c);
      end
    end
  endtask

  task automatic test_normal();
    vec_t t[$];
    exp_t e;
    do_reset();
    t = {v(0, 0, 0, 0, 0, O_IDLE, 0), v(1, 0, 0, 0, 0, O_W1, 0),
         v(1, 0, 0, 0, 0, O_W2, 0),   v(1, 0, 0, 0, 0, O_W1, 1),
         v(1, 0, 0, 0, 0, O_W2, 1),   v(1, 0, 0, 0, 0, O_W1, 2)};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({running, w3, w2, w1} !== e.o || cyc_cnt !== e.c) begin
        tests_failed++;
        $display("FAIL normal[%0d]: outs=%b cnt=%0d, want outs=%b cnt=%0d",
                 i, {running, w3, w2, w1}, cyc_cnt, e.o, e.c);
      end
    end
  endtask

  task automatic test_long_short();
    vec_t t[$];
    exp_t e;
    do_reset();
    t = {v(0, 0, 0, 0, 0, O_IDLE, 0), v(1, 0, 0, 0, 0, O_W1, 0),
         v(1, 0, 0, 1, 0, O_W2, 0),   // long ignored in W1
         v(1, 0, 0, 1, 0, O_W3, 0),   // long in W2
         v(1, 0, 0, 0, 0, O_W1, 1),
         v(1, 0, 1, 1, 0, O_W1, 2),   // short beats long in W1
         v(1, 0, 1, 1, 0, O_W1, 3),
         v(1, 0, 0, 0, 0, O_W2, 3),
         v(1, 0, 1, 0, 0, O_W1, 4),   // short ignored in W2
         v(1, 0, 0, 0, 0, O_W2, 4),
         v(1, 0, 0, 1, 0, O_W3, 4),
         v(1, 0, 1, 0, 0, O_W1, 5)};  // short ignored in W3
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({running, w3, w2, w1} !== e.o || cyc_cnt !== e.c) begin
        tests_failed++;
        $display("FAIL long_short[%0d]: outs=%b cnt=%0d, want outs=%b cnt=%0d",
                 i, {running, w3, w2, w1}, cyc_cnt, e.o, e.c);
      end
    end
  endtask

  task automatic test_step();
    vec_t t[$];
    exp_t e;
    do_reset();
    t = {v(0, 1, 0, 0, 0, O_IDLE, 0), v(1, 1, 0, 0, 0, O_W1, 0),
         v(0, 0, 0, 0, 0, O_W2, 0),   // step low mid-cycle has no effect
         v(0, 1, 0, 0, 0, O_IDLE, 1), v(0, 1, 0, 0, 0, O_IDLE, 1),
         v(1, 1, 0, 0, 0, O_W1, 1),   v(1, 1, 0, 0, 0, O_W2, 1),
         v(1, 1, 0, 0, 0, O_IDLE, 2), v(1, 1, 0, 0, 0, O_IDLE, 2)};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({running, w3, w2, w1} !== e.o || cyc_cnt !== e.c) begin
        tests_failed++;
        $display("FAIL step[%0d]: outs=%b cnt=%0d, want outs=%b cnt=%0d",
                 i, {running, w3, w2, w1}, cyc_cnt, e.o, e.c);
      end
    end
  endtask

  task automatic test_stop_wrap();
    vec_t t[$];
    exp_t e;
    do_reset();
    t.push_back(v(0, 0, 0, 0, 0, O_IDLE, 0));
    t.push_back(v(1, 0, 0, 0, 0, O_W1, 0));
    // qd toggles throughout: edges while running must not disturb anything
    for (int i = 0; i < 15; i++) begin
      t.push_back(v(i[0], 0, 0, 0, 0, O_W2, i));
      t.push_back(v(~i[0], 0, 0, 0, 0, O_W1, i + 1));
    end
    t.push_back(v(1, 0, 0, 0, 0, O_W2, 15));
    t.push_back(v(1, 0, 0, 0, 1, O_IDLE, 0));   // stop in W2, counter wraps
    t.push_back(v(1, 0, 0, 0, 0, O_IDLE, 0));   // qd still high: no restart
    t.push_back(v(0, 0, 0, 0, 0, O_IDLE, 0));
    t.push_back(v(1, 0, 0, 0, 0, O_W1, 0));
    t.push_back(v(1, 0, 0, 0, 1, O_IDLE, 1));   // stop in W1 counts
    t.push_back(v(0, 0, 0, 0, 0, O_IDLE, 1));
    t.push_back(v(1, 0, 0, 0, 0, O_W1, 1));
    t.push_back(v(1, 0, 0, 1, 0, O_W2, 1));
    t.push_back(v(1, 0, 0, 1, 0, O_W3, 1));
    t.push_back(v(1, 0, 0, 0, 1, O_IDLE, 2));   // stop in W3 counts
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({running, w3, w2, w1} !== e.o || cyc_cnt !== e.c) begin
        tests_failed++;
        $display("FAIL stop_wrap[%0d]: outs=%b cnt=%0d, want outs=%b cnt=%0d",
                 i, {running, w3, w2, w1}, cyc_cnt, e.o, e.c);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t t[$];
    exp_t e;
    do_reset();
    t = {v(0, 0, 0, 0, 0, O_IDLE, 0), v(1, 0, 0, 0, 0, O_W1, 0),
         v(1, 0, 0, 0, 0, O_W2, 0),   v(1, 0, 0, 0, 0, O_W1, 1),
         v(1, 0, 0, 1, 0, O_W2, 1),   v(1, 0, 0, 1, 0, O_W3, 1)};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({running, w3, w2, w1} !== e.o || cyc_cnt !== e.c) begin
        tests_failed++;
        $display("FAIL async_pre[%0d]: outs=%b cnt=%0d, want outs=%b cnt=%0d",
                 i, {running, w3, w2, w1}, cyc_cnt, e.o, e.c);
      end
    end
    // mid-W3, well before the next t3 edge
    #1;
    clr = 1'b0;
    #1;
    tests_run++;
    if ({running, w3, w2, w1} !== O_IDLE || cyc_cnt !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: outs=%b cnt=%0d, want outs=%b cnt=0",
               {running, w3, w2, w1}, cyc_cnt, O_IDLE);
    end
    tick();
    clr = 1'b1;
    t = {v(1, 0, 0, 0, 0, O_IDLE, 0), v(0, 0, 0, 0, 0, O_IDLE, 0),
         v(1, 0, 0, 0, 0, O_W1, 0)};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if ({running, w3, w2, w1} !== e.o || cyc_cnt !== e.c) begin
        tests_failed++;
        $display("FAIL async_post[%0d]: outs=%b cnt=%0d, want outs=%b cnt=%0d",
                 i, {running, w3, w2, w1}, cyc_cnt, e.o, e.c);
      end
    end
  endtask

  initial begin
    clr = 1'b0; qd = 1'b1; step = 0; short = 0; long = 0; stop = 0;
    tick();
    test_reset();
    test_normal();
    test_long_short();
    test_step();
    test_stop_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
